// File: rtl/ram_mutex_stack_n_pkg.sv
// Shared types for the mutex-guarded frame stack memory:
// command codes, error codes, word headers and lock state.
package ram_mutex_pkg;

   typedef enum logic [1:0] {
      F_READ  = 2'b00,
      F_WRITE = 2'b01,
      F_POP   = 2'b10,
      F_PUSH  = 2'b11
   } func_e;

   typedef enum logic [2:0] {
      E_OK      = 3'd0,
      E_OVF     = 3'd1,
      E_UNF     = 3'd2,
      E_RANGE   = 3'd3,
      E_TIMEOUT = 3'd4
   } err_e;

   localparam logic [3:0] HDR_START = 4'hF;
   localparam logic [3:0] HDR_STOP  = 4'hF;
   localparam int         PRIO_W    = 4;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } state_e;

endpackage

// File: rtl/ram_mutex_stack_n_if.sv
// Node-fabric side bundle of the frame stack memory:
// per-node op words in, owner/response/status out.
interface ram_mutex_stack_n_if #(
   parameter int NODES  = 4,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic [NODES*(DATA_W+8)-1:0] in_op;
   logic [NODES-1:0]            in_vld;
   logic [NODES-1:0]            out_grant;
   logic                        out_valid;
   logic [DATA_W-1:0]           out_data;
   logic [2:0]                  out_err;
   logic [ADDR_W:0]             out_sp;
   logic [ADDR_W:0]             out_fp;

   modport master (
      output in_op,
      output in_vld,
      input  out_grant,
      input  out_valid,
      input  out_data,
      input  out_err,
      input  out_sp,
      input  out_fp
   );

   modport slave (
      input  in_op,
      input  in_vld,
      output out_grant,
      output out_valid,
      output out_data,
      output out_err,
      output out_sp,
      output out_fp
   );
endinterface

// File: rtl/ram_mutex_stack_n_arb.sv
// Priority-then-round-robin arbiter: highest priority wins,
// ties resolved starting at the node after the last owner.
module prio_rr_arbiter #(
   parameter int NODES  = 4,
   parameter int PRIO_W = 4
) (
   input  logic [NODES-1:0]        req,
   input  logic [NODES*PRIO_W-1:0] prio,
   input  logic [((NODES > 1) ? $clog2(NODES) : 1)-1:0] last,
   output logic [NODES-1:0]        grant
);
   logic [PRIO_W-1:0] top;
   logic              hit;
   int                idx;

   always_comb begin
      top = '0;
      for (int i = 0; i < NODES; i++) begin
         if (req[i] && prio[i*PRIO_W +: PRIO_W] > top)
            top = prio[i*PRIO_W +: PRIO_W];
      end
   end

   // Scan from last+1 around the ring; first requester at top priority wins.
   always_comb begin
      grant = '0;
      hit   = 1'b0;
      idx   = 0;
      for (int k = 1; k <= NODES; k++) begin
         idx = int'(last) + k;
         if (idx >= NODES)
            idx = idx - NODES;
         if (!hit && req[idx] &&
             prio[idx*PRIO_W +: PRIO_W] == top) begin
            grant[idx] = 1'b1;
            hit        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ram_mutex_stack_n.sv
// N-node mutex-guarded frame stack memory with tagged
// read/write/push/pop commands and an owner idle timeout.
module ram_mutex_stack_n
   import ram_mutex_pkg::*;
#(
   parameter int         NODES   = 4,
   parameter int         DATA_W  = 8,
   parameter int         ADDR_W  = 8,
   parameter logic [3:0] TAG     = 4'b1100,
   parameter int         TIMEOUT = 256
) (
   input logic                CLK,
   input logic                RST_N,
   ram_mutex_stack_n_if.slave bus
);
   localparam int W     = DATA_W + 8;
   localparam int DEPTH = 1 << ADDR_W;
   localparam int AW1   = ADDR_W + 1;
   localparam int PTR_W = (NODES > 1) ? $clog2(NODES) : 1;
   localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int SW    = ((AW1 > DATA_W) ? AW1 : DATA_W) + 1;
   localparam logic [AW1-1:0] FULL = AW1'(DEPTH);

   if (DATA_W < ADDR_W) begin : g_bad_width
      $error("DATA_W must be >= ADDR_W");
   end
   if (NODES < 2 || NODES > 16) begin : g_bad_nodes
      $error("NODES must be in 2..16");
   end

   function automatic logic is_start(input logic [W-1:0] w);
      return w[W-1 -: 4] == HDR_START && w[W-5 -: 4] == TAG &&
             w[3:0] != 4'h0 && (w[DATA_W-1:0] >> 4) == '0;
   endfunction

   function automatic logic is_stop(input logic [W-1:0] w);
      return w[W-1 -: 4] == HDR_STOP && w[W-5 -: 4] == TAG &&
             w[DATA_W-1:0] == '1;
   endfunction

   function automatic logic is_cmd(input logic [W-1:0] w);
      return w[W-1 -: 2] != 2'b11 && w[W-5 -: 4] == TAG;
   endfunction

   state_e               state_q, state_d;
   logic [PTR_W-1:0]     own_q, own_d, last_q, last_d;
   logic [NODES-1:0]     grant_q, grant_d;
   logic [TW-1:0]        idle_q, idle_d;
   logic [AW1-1:0]       sp_q, sp_d, fp_q, fp_d;
   logic [AW1-1:0]       link_q, link_d, link_cur, q_link;
   logic                 lpend_q, lpend_d;
   logic                 vld_q, vld_d, rdv_q, rdv_d;
   err_e                 err_q, err_d;

   logic [NODES-1:0]        req, arb_grant;
   logic [NODES*PRIO_W-1:0] prio;
   logic [PTR_W-1:0]        arb_idx;

   logic [W-1:0]      own_word;
   logic              own_vld;
   logic [DATA_W-1:0] pay;
   func_e             func;
   logic [SW-1:0]     rd_sum;

   logic              we, re;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wd, ram_q;
   logic [DATA_W-1:0] mem [DEPTH];

   always_comb begin
      req  = '0;
      prio = '0;
      for (int i = 0; i < NODES; i++) begin
         req[i] = bus.in_vld[i] && is_start(bus.in_op[i*W +: W]);
         prio[i*PRIO_W +: PRIO_W] = bus.in_op[i*W +: PRIO_W];
      end
   end

   prio_rr_arbiter #(
      .NODES  (NODES),
      .PRIO_W (PRIO_W)
   ) u_arb (
      .req   (req),
      .prio  (prio),
      .last  (last_q),
      .grant (arb_grant)
   );

   always_comb begin
      arb_idx = '0;
      for (int i = 0; i < NODES; i++) begin
         if (arb_grant[i])
            arb_idx = PTR_W'(i);
      end
   end

   assign own_word = bus.in_op[own_q*W +: W];
   assign own_vld  = bus.in_vld[own_q];
   assign pay      = own_word[DATA_W-1:0];
   assign func     = func_e'(own_word[W-3 -: 2]);
   assign rd_sum   = SW'(fp_q) + SW'(pay);

   // Link of the open frame: held in link_q, or arriving from RAM after a pop.
   assign q_link   = AW1'(ram_q);
   assign link_cur = lpend_q ? q_link : link_q;

   always_comb begin
      state_d = state_q;
      own_d   = own_q;
      last_d  = last_q;
      grant_d = grant_q;
      idle_d  = idle_q;
      sp_d    = sp_q;
      fp_d    = fp_q;
      link_d  = link_cur;
      lpend_d = 1'b0;
      vld_d   = 1'b0;
      rdv_d   = 1'b0;
      err_d   = E_OK;
      we      = 1'b0;
      re      = 1'b0;
      addr    = '0;
      wd      = '0;
      unique case (state_q)
         UNLOCKED: begin
            if (|arb_grant) begin
               state_d = LOCKED;
               own_d   = arb_idx;
               last_d  = arb_idx;
               grant_d = arb_grant;
               idle_d  = '0;
            end
         end
         LOCKED: begin
            if (own_vld) begin
               idle_d = '0;
               unique case (1'b1)
                  is_stop(own_word): begin
                     state_d = UNLOCKED;
                     grant_d = '0;
                     vld_d   = 1'b1;
                  end
                  is_start(own_word): vld_d = 1'b1;
                  is_cmd(own_word): begin
                     vld_d = 1'b1;
                     unique case (func)
                        F_READ: begin
                           if (rd_sum >= SW'(sp_q)) begin
                              err_d = E_RANGE;
                           end else begin
                              re    = 1'b1;
                              addr  = rd_sum[ADDR_W-1:0];
                              rdv_d = 1'b1;
                           end
                        end
                        F_WRITE: begin
                           if (sp_q == FULL) begin
                              err_d = E_OVF;
                           end else begin
                              we   = 1'b1;
                              addr = sp_q[ADDR_W-1:0];
                              wd   = pay;
                              sp_d = sp_q + AW1'(1);
                              if (sp_q == fp_q)
                                 link_d = AW1'(pay);
                           end
                        end
                        F_PUSH: begin
                           if (sp_q == FULL) begin
                              err_d = E_OVF;
                           end else begin
                              we     = 1'b1;
                              addr   = sp_q[ADDR_W-1:0];
                              wd     = DATA_W'(fp_q);
                              link_d = fp_q;
                              fp_d   = sp_q;
                              sp_d   = sp_q + AW1'(1);
                           end
                        end
                        F_POP: begin
                           if (fp_q == sp_q) begin
                              err_d = E_UNF;
                           end else begin
                              sp_d    = fp_q;
                              fp_d    = link_cur;
                              re      = 1'b1;
                              addr    = link_cur[ADDR_W-1:0];
                              lpend_d = 1'b1;
                           end
                        end
                        default: ;
                     endcase
                  end
                  default: ;
               endcase
            end else if (TIMEOUT != 0) begin
               if (idle_q == TW'(TIMEOUT - 1)) begin
                  state_d = UNLOCKED;
                  grant_d = '0;
                  idle_d  = '0;
                  vld_d   = 1'b1;
                  err_d   = E_TIMEOUT;
               end else begin
                  idle_d = idle_q + TW'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= UNLOCKED;
         own_q   <= '0;
         last_q  <= '0;
         grant_q <= '0;
         idle_q  <= '0;
         sp_q    <= '0;
         fp_q    <= '0;
         link_q  <= '0;
         lpend_q <= 1'b0;
         vld_q   <= 1'b0;
         rdv_q   <= 1'b0;
         err_q   <= E_OK;
      end else begin
         state_q <= state_d;
         own_q   <= own_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         idle_q  <= idle_d;
         sp_q    <= sp_d;
         fp_q    <= fp_d;
         link_q  <= link_d;
         lpend_q <= lpend_d;
         vld_q   <= vld_d;
         rdv_q   <= rdv_d;
         err_q   <= err_d;
      end
   end

   // Single-port RAM; contents survive reset.
   always_ff @(posedge CLK) begin
      if (we)
         mem[addr] <= wd;
      else if (re)
         ram_q <= mem[addr];
   end

   assign bus.out_grant = grant_q;
   assign bus.out_valid = vld_q;
   assign bus.out_data  = rdv_q ? ram_q : '0;
   assign bus.out_err   = err_q;
   assign bus.out_sp    = sp_q;
   assign bus.out_fp    = fp_q;

endmodule

// File: tb/tb_ram_mutex_stack_n.sv
// Directed bench for ram_mutex_stack_n: arbitration, stack
// commands, overflow, timeout and reset mid-operation.
module tb_ram_mutex_stack_n;
   import ram_mutex_pkg::*;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   int   checks = 0;
   int   failures = 0;

   logic [15:0] op0 [4];
   logic [15:0] op1 [4];
   logic [3:0]  v0;
   logic [3:0]  v1;

   ram_mutex_stack_n_if #(.NODES(4), .DATA_W(8), .ADDR_W(8)) bus0 ();
   ram_mutex_stack_n_if #(.NODES(4), .DATA_W(8), .ADDR_W(2)) bus1 ();

   assign bus0.in_op  = {op0[3], op0[2], op0[1], op0[0]};
   assign bus0.in_vld = v0;
   assign bus1.in_op  = {op1[3], op1[2], op1[1], op1[0]};
   assign bus1.in_vld = v1;

   ram_mutex_stack_n #(
      .NODES(4), .DATA_W(8), .ADDR_W(8), .TAG(4'b1100), .TIMEOUT(8)
   ) dut0 (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus0)
   );

   ram_mutex_stack_n #(
      .NODES(4), .DATA_W(8), .ADDR_W(2), .TAG(4'b1100), .TIMEOUT(0)
   ) dut1 (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus1)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   function automatic logic [15:0] w_start(input logic [3:0] p);
      return {4'hF, 4'hC, 4'h0, p};
   endfunction

   function automatic logic [15:0] w_stop();
      return {4'hF, 4'hC, 8'hFF};
   endfunction

   function automatic logic [15:0] w_cmd(input logic [1:0] f,
                                         input logic [7:0] p);
      return {2'b00, f, 4'hC, p};
   endfunction

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic clear_inputs();
      v0 = '0;
      v1 = '0;
      for (int i = 0; i < 4; i++) begin
         op0[i] = '0;
         op1[i] = '0;
      end
   endtask

   task automatic do_reset();
      clear_inputs();
      RST_N = 1'b0;
      tick();
      RST_N = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      clear_inputs();
      RST_N = 1'b0;
      tick();
      tick();
      checks++;
      if (bus0.out_grant !== 4'b0000) begin
         failures++; $display("FAIL rst_grant got=%b exp=0000", bus0.out_grant);
      end
      checks++;
      if (bus0.out_valid !== 1'b0) begin
         failures++; $display("FAIL rst_valid got=%b exp=0", bus0.out_valid);
      end
      checks++;
      if (bus0.out_data !== 8'h00) begin
         failures++; $display("FAIL rst_data got=%h exp=00", bus0.out_data);
      end
      checks++;
      if (bus0.out_err !== 3'd0) begin
         failures++; $display("FAIL rst_err got=%0d exp=0", bus0.out_err);
      end
      checks++;
      if (bus0.out_sp !== 9'd0 || bus0.out_fp !== 9'd0) begin
         failures++;
         $display("FAIL rst_ptr got sp=%0d fp=%0d exp 0/0", bus0.out_sp, bus0.out_fp);
      end
      RST_N = 1'b1;
      tick();
   endtask

   task automatic test_priority();
      do_reset();
      op0[0] = w_start(4'd3);
      op0[2] = w_start(4'd9);
      v0 = 4'b0101;
      tick();
      checks++;
      if (bus0.out_grant !== 4'b0100) begin
         failures++; $display("FAIL prio_grant got=%b exp=0100", bus0.out_grant);
      end
      op0[2] = w_stop();
      tick();
      checks++;
      if (bus0.out_grant !== 4'b0000 || bus0.out_valid !== 1'b1 || bus0.out_err !== 3'd0) begin
         failures++;
         $display("FAIL prio_stop got g=%b v=%b e=%0d exp 0000/1/0",
                  bus0.out_grant, bus0.out_valid, bus0.out_err);
      end
      op0[0] = w_start(4'd5);
      op0[2] = w_start(4'd5);
      tick();
      checks++;
      if (bus0.out_grant !== 4'b0001) begin
         failures++; $display("FAIL tie_rr_grant got=%b exp=0001", bus0.out_grant);
      end
      op0[0] = w_stop();
      v0 = 4'b0001;
      tick();
      checks++;
      if (bus0.out_grant !== 4'b0000) begin
         failures++; $display("FAIL tie_stop got=%b exp=0000", bus0.out_grant);
      end
      v0 = '0;
      tick();
   endtask

   task automatic test_stack();
      do_reset();
      op0[1] = w_start(4'd1);
      v0 = 4'b0010;
      tick();
      checks++;
      if (bus0.out_grant !== 4'b0010) begin
         failures++; $display("FAIL stk_grant got=%b exp=0010", bus0.out_grant);
      end
      op0[1] = w_cmd(F_PUSH, 8'h00);
      tick();
      op0[1] = w_cmd(F_WRITE, 8'hAA);
      tick();
      op0[1] = w_cmd(F_WRITE, 8'h55);
      tick();
      checks++;
      if (bus0.out_sp !== 9'd3 || bus0.out_fp !== 9'd0 || bus0.out_err !== 3'd0) begin
         failures++;
         $display("FAIL stk_ptr got sp=%0d fp=%0d e=%0d exp 3/0/0",
                  bus0.out_sp, bus0.out_fp, bus0.out_err);
      end
      op0[1] = w_cmd(F_READ, 8'd2);
      tick();
      checks++;
      if (bus0.out_valid !== 1'b1 || bus0.out_data !== 8'h55 || bus0.out_err !== 3'd0) begin
         failures++;
         $display("FAIL stk_read2 got v=%b d=%h e=%0d exp 1/55/0",
                  bus0.out_valid, bus0.out_data, bus0.out_err);
      end
      op0[1] = w_cmd(F_READ, 8'd3);
      tick();
      checks++;
      if (bus0.out_err !== 3'd3 || bus0.out_data !== 8'h00) begin
         failures++;
         $display("FAIL stk_range got e=%0d d=%h exp 3/00", bus0.out_err, bus0.out_data);
      end
      op0[1] = w_stop();
      tick();
      v0 = '0;
      tick();
   endtask

   task automatic test_pop();
      do_reset();
      op0[0] = w_start(4'd7);
      v0 = 4'b0001;
      tick();
      op0[0] = w_cmd(F_PUSH, 8'h00);
      tick();
      op0[0] = w_cmd(F_WRITE, 8'h11);
      tick();
      op0[0] = w_cmd(F_PUSH, 8'h00);
      tick();
      checks++;
      if (bus0.out_sp !== 9'd3 || bus0.out_fp !== 9'd2) begin
         failures++;
         $display("FAIL pop_push2 got sp=%0d fp=%0d exp 3/2", bus0.out_sp, bus0.out_fp);
      end
      op0[0] = w_cmd(F_WRITE, 8'h22);
      tick();
      op0[0] = w_cmd(F_POP, 8'h00);
      tick();
      checks++;
      if (bus0.out_sp !== 9'd2 || bus0.out_fp !== 9'd0 || bus0.out_err !== 3'd0) begin
         failures++;
         $display("FAIL pop_1 got sp=%0d fp=%0d e=%0d exp 2/0/0",
                  bus0.out_sp, bus0.out_fp, bus0.out_err);
      end
      tick();
      checks++;
      if (bus0.out_sp !== 9'd0 || bus0.out_fp !== 9'd0 || bus0.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL pop_2 got sp=%0d fp=%0d v=%b exp 0/0/1",
                  bus0.out_sp, bus0.out_fp, bus0.out_valid);
      end
      tick();
      checks++;
      if (bus0.out_err !== 3'd2 || bus0.out_valid !== 1'b1 || bus0.out_sp !== 9'd0) begin
         failures++;
         $display("FAIL pop_unf got e=%0d v=%b sp=%0d exp 2/1/0",
                  bus0.out_err, bus0.out_valid, bus0.out_sp);
      end
      op0[0] = w_stop();
      tick();
      v0 = '0;
      tick();
   endtask

   task automatic test_back_to_back();
      do_reset();
      op0[3] = w_start(4'd4);
      v0 = 4'b1000;
      tick();
      op0[3] = w_cmd(F_WRITE, 8'h3C);
      op0[1] = w_cmd(F_WRITE, 8'h77);
      v0 = 4'b1010;
      tick();
      checks++;
      if (bus0.out_sp !== 9'd1) begin
         failures++; $display("FAIL b2b_nonowner got sp=%0d exp=1", bus0.out_sp);
      end
      op0[3] = w_cmd(F_READ, 8'd0);
      tick();
      checks++;
      if (bus0.out_data !== 8'h3C || bus0.out_err !== 3'd0) begin
         failures++;
         $display("FAIL b2b_wfirst got d=%h e=%0d exp 3c/0", bus0.out_data, bus0.out_err);
      end
      op0[3] = w_start(4'd9);
      tick();
      checks++;
      if (bus0.out_valid !== 1'b1 || bus0.out_err !== 3'd0 ||
          bus0.out_grant !== 4'b1000 || bus0.out_data !== 8'h00) begin
         failures++;
         $display("FAIL b2b_restart got v=%b e=%0d g=%b d=%h exp 1/0/1000/00",
                  bus0.out_valid, bus0.out_err, bus0.out_grant, bus0.out_data);
      end
      op0[3] = w_stop();
      v0 = 4'b1000;
      tick();
      v0 = '0;
      tick();
   endtask

   task automatic test_overflow();
      do_reset();
      op1[0] = w_start(4'd1);
      v1 = 4'b0001;
      tick();
      checks++;
      if (bus1.out_grant !== 4'b0001) begin
         failures++; $display("FAIL ovf_grant got=%b exp=0001", bus1.out_grant);
      end
      for (int i = 0; i < 4; i++) begin
         op1[0] = w_cmd(F_WRITE, 8'(i + 1));
         tick();
      end
      checks++;
      if (bus1.out_sp !== 3'd4 || bus1.out_err !== 3'd0) begin
         failures++;
         $display("FAIL ovf_fill got sp=%0d e=%0d exp 4/0", bus1.out_sp, bus1.out_err);
      end
      op1[0] = w_cmd(F_WRITE, 8'h05);
      tick();
      checks++;
      if (bus1.out_err !== 3'd1 || bus1.out_valid !== 1'b1 || bus1.out_sp !== 3'd4) begin
         failures++;
         $display("FAIL ovf_fifth got e=%0d v=%b sp=%0d exp 1/1/4",
                  bus1.out_err, bus1.out_valid, bus1.out_sp);
      end
      op1[0] = w_stop();
      tick();
      v1 = '0;
      tick();
   endtask

   task automatic test_timeout();
      do_reset();
      op0[0] = w_start(4'd2);
      v0 = 4'b0001;
      tick();
      checks++;
      if (bus0.out_grant !== 4'b0001) begin
         failures++; $display("FAIL to_grant got=%b exp=0001", bus0.out_grant);
      end
      op0[3] = w_start(4'd1);
      v0 = 4'b1000;
      repeat (7) tick();
      checks++;
      if (bus0.out_grant !== 4'b0001 || bus0.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL to_early got g=%b v=%b exp 0001/0", bus0.out_grant, bus0.out_valid);
      end
      tick();
      checks++;
      if (bus0.out_valid !== 1'b1 || bus0.out_err !== 3'd4 || bus0.out_grant !== 4'b0000) begin
         failures++;
         $display("FAIL to_fire got v=%b e=%0d g=%b exp 1/4/0000",
                  bus0.out_valid, bus0.out_err, bus0.out_grant);
      end
      tick();
      checks++;
      if (bus0.out_grant !== 4'b1000) begin
         failures++; $display("FAIL to_next got=%b exp=1000", bus0.out_grant);
      end
      op0[3] = w_stop();
      tick();
      v0 = '0;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      op0[2] = w_start(4'd6);
      v0 = 4'b0100;
      tick();
      op0[2] = w_cmd(F_PUSH, 8'h00);
      tick();
      op0[2] = w_cmd(F_WRITE, 8'h99);
      tick();
      checks++;
      if (bus0.out_sp !== 9'd2 || bus0.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL mid_pre got sp=%0d v=%b exp 2/1", bus0.out_sp, bus0.out_valid);
      end
      op0[2] = w_cmd(F_WRITE, 8'h44);
      RST_N = 1'b0;
      #1;
      checks++;
      if (bus0.out_grant !== 4'b0000 || bus0.out_valid !== 1'b0 ||
          bus0.out_data !== 8'h00 || bus0.out_err !== 3'd0) begin
         failures++;
         $display("FAIL mid_out got g=%b v=%b d=%h e=%0d exp 0000/0/00/0",
                  bus0.out_grant, bus0.out_valid, bus0.out_data, bus0.out_err);
      end
      checks++;
      if (bus0.out_sp !== 9'd0 || bus0.out_fp !== 9'd0) begin
         failures++;
         $display("FAIL mid_ptr got sp=%0d fp=%0d exp 0/0", bus0.out_sp, bus0.out_fp);
      end
      tick();
      v0 = '0;
      RST_N = 1'b1;
      tick();
      op0[1] = w_start(4'd3);
      v0 = 4'b0010;
      tick();
      checks++;
      if (bus0.out_grant !== 4'b0010) begin
         failures++; $display("FAIL mid_regrant got=%b exp=0010", bus0.out_grant);
      end
      op0[1] = w_stop();
      tick();
      v0 = '0;
      tick();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_priority();
      test_stack();
      test_pop();
      test_back_to_back();
      test_overflow();
      test_timeout();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
